// File: rtl/multiplier_cp_sliced.sv
// Control path for the slice-based iterative RV32M multiplier.
// Sequences N_LANES sub-multipliers over the SxS partial-product grid and drives the datapath controls.
module multiplier_cp_sliced #(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 8,
    parameter int N_LANES = 4,
    localparam int S   = XLEN / SLICE_W,
    localparam int P   = S * S / N_LANES,
    localparam int SW  = (S > 1) ? $clog2(S) : 1,
    localparam int SHW = (S > 1) ? $clog2(2 * S - 1) : 1,
    localparam int CW  = (P > 1) ? $clog2(P) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [1:0]             op_i,
    input  logic                   zero_i,
    input  logic                   flush_i,
    input  logic                   done_ack_i,
    output logic                   busy_o,
    output logic                   reg_a_en_o,
    output logic                   reg_b_en_o,
    output logic                   ac_clr_o,
    output logic                   ac_en_o,
    output logic [N_LANES-1:0]     lane_en_o,
    output logic [N_LANES*SW-1:0]  sel_a_o,
    output logic [N_LANES*SW-1:0]  sel_b_o,
    output logic [N_LANES-1:0]     sign_a_o,
    output logic [N_LANES-1:0]     sign_b_o,
    output logic [N_LANES*SHW-1:0] shift_o,
    output logic                   hi_sel_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_MULT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0]    OP_MUL    = 2'b00;
    localparam logic [1:0]    OP_MULH   = 2'b01;
    localparam logic [1:0]    OP_MULHSU = 2'b10;
    localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_op;
    logic [1:0]    w_op_nxt;

    // State, pass counter and captured opcode; reset acts immediately, even mid-operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Next-state logic; flush wins over zero early-out and ack.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_state_nxt = ST_LOAD;
                    w_op_nxt    = op_i;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_cnt_nxt = '0;
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (zero_i) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_MULT;
                end
            end
            ST_MULT: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (done_ack_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode; lane k of pass p covers grid cell j = p*N_LANES + k.
    always_comb begin
        int w_j;
        int w_ia;
        int w_ib;
        int w_sh;
        logic w_en;
        logic w_sa;
        logic w_sb;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        reg_a_en_o = 1'b0;
        reg_b_en_o = 1'b0;
        ac_clr_o   = 1'b0;
        ac_en_o    = 1'b0;
        lane_en_o  = '0;
        sel_a_o    = '0;
        sel_b_o    = '0;
        sign_a_o   = '0;
        sign_b_o   = '0;
        shift_o    = '0;
        hi_sel_o   = 1'b0;
        done_o     = 1'b0;
        w_j        = 0;
        w_ia       = 0;
        w_ib       = 0;
        w_sh       = 0;
        w_en       = 1'b0;
        w_sa       = (r_op == OP_MULH) || (r_op == OP_MULHSU);
        w_sb       = (r_op == OP_MULH);
        case (r_state)
            ST_IDLE: begin
                ready_o = 1'b1;
            end
            ST_LOAD: begin
                busy_o     = 1'b1;
                reg_a_en_o = 1'b1;
                reg_b_en_o = 1'b1;
                ac_clr_o   = 1'b1;
            end
            ST_MULT: begin
                busy_o  = 1'b1;
                ac_en_o = 1'b1;
                for (int k = 0; k < N_LANES; k++) begin
                    w_j  = int'(r_cnt) * N_LANES + k;
                    w_ia = w_j % S;
                    w_ib = w_j / S;
                    w_sh = w_ia + w_ib;
                    // Low-half-only ops skip products that land entirely above bit XLEN-1.
                    w_en = !((r_op == OP_MUL) && (w_sh >= S));
                    lane_en_o[k]            = w_en;
                    sel_a_o[k*SW +: SW]     = SW'(w_ia);
                    sel_b_o[k*SW +: SW]     = SW'(w_ib);
                    shift_o[k*SHW +: SHW]   = SHW'(w_sh);
                    sign_a_o[k]             = w_en && w_sa && (w_ia == S - 1);
                    sign_b_o[k]             = w_en && w_sb && (w_ib == S - 1);
                end
            end
            ST_DONE: begin
                done_o   = 1'b1;
                hi_sel_o = (r_op != OP_MUL);
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_cp_sliced.sv
// Scoreboard bench for multiplier_cp_sliced: per-cycle expected control words are queued as
// stimulus is driven and compared at the falling edge; a second instance covers N_LANES=2.
module tb_multiplier_cp_sliced;

    localparam int TNL  = 4;
    localparam int TS   = 4;
    localparam int TP   = 4;
    localparam int TSW  = 2;
    localparam int TSHW = 3;

    typedef struct packed {
        logic                 ready;
        logic                 busy;
        logic [2:0]           ld;
        logic                 ac;
        logic [TNL-1:0]       lane;
        logic [TNL-1:0]       sa;
        logic [TNL-1:0]       sb;
        logic [TNL*TSW-1:0]   sela;
        logic [TNL*TSW-1:0]   selb;
        logic [TNL*TSHW-1:0]  shift;
        logic                 done;
        logic                 hi;
    } obs_t;

    logic clk, rst;
    logic valid, zero, flush, ack;
    logic [1:0] op;
    logic ready, busy, reg_a_en, reg_b_en, ac_clr, ac_en, hi_sel, done;
    logic [TNL-1:0] lane_en, sign_a, sign_b;
    logic [TNL*TSW-1:0] sel_a, sel_b;
    logic [TNL*TSHW-1:0] shift;

    logic valid2, ack2;
    logic ready2, busy2, reg_a_en2, reg_b_en2, ac_clr2, ac_en2, hi_sel2, done2;
    logic [1:0] lane_en2, sign_a2, sign_b2;
    logic [3:0] sel_a2, sel_b2;
    logic [5:0] shift2;

    int n_pass  = 0;
    int n_total = 0;
    obs_t exp_q[$];
    logic [TNL-1:0]      lane_log [TP];
    logic [TNL-1:0]      sa_log   [TP];
    logic [TNL-1:0]      sb_log   [TP];
    logic [TNL*TSW-1:0]  sela_log [TP];
    logic [TNL*TSW-1:0]  selb_log [TP];
    logic [TNL*TSHW-1:0] sh_log   [TP];

    multiplier_cp_sliced dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .op_i(op),
        .zero_i(zero), .flush_i(flush), .done_ack_i(ack), .busy_o(busy),
        .reg_a_en_o(reg_a_en), .reg_b_en_o(reg_b_en), .ac_clr_o(ac_clr), .ac_en_o(ac_en),
        .lane_en_o(lane_en), .sel_a_o(sel_a), .sel_b_o(sel_b), .sign_a_o(sign_a),
        .sign_b_o(sign_b), .shift_o(shift), .hi_sel_o(hi_sel), .done_o(done)
    );

    multiplier_cp_sliced #(.N_LANES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid2), .ready_o(ready2), .op_i(2'b11),
        .zero_i(1'b0), .flush_i(1'b0), .done_ack_i(ack2), .busy_o(busy2),
        .reg_a_en_o(reg_a_en2), .reg_b_en_o(reg_b_en2), .ac_clr_o(ac_clr2), .ac_en_o(ac_en2),
        .lane_en_o(lane_en2), .sel_a_o(sel_a2), .sel_b_o(sel_b2), .sign_a_o(sign_a2),
        .sign_b_o(sign_b2), .shift_o(shift2), .hi_sel_o(hi_sel2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic obs_t idle_exp();
        obs_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic obs_t load_exp();
        obs_t e;
        e = '0;
        e.busy = 1'b1;
        e.ld   = 3'b111;
        return e;
    endfunction

    function automatic obs_t done_exp(input logic [1:0] o);
        obs_t e;
        e = '0;
        e.done = 1'b1;
        e.hi   = (o != 2'b00);
        return e;
    endfunction

    function automatic obs_t mult_exp(input logic [1:0] o, input int p);
        obs_t e;
        int j, ia, ib, sh;
        logic en;
        e = '0;
        e.busy = 1'b1;
        e.ac   = 1'b1;
        for (int k = 0; k < TNL; k++) begin
            j  = p * TNL + k;
            ia = j % TS;
            ib = j / TS;
            sh = ia + ib;
            en = !((o == 2'b00) && (sh >= TS));
            e.lane[k] = en;
            e.sela[k*TSW +: TSW]    = TSW'(ia);
            e.selb[k*TSW +: TSW]    = TSW'(ib);
            e.shift[k*TSHW +: TSHW] = TSHW'(sh);
            e.sa[k] = en && ((o == 2'b01) || (o == 2'b10)) && (ia == TS - 1);
            e.sb[k] = en && (o == 2'b01) && (ib == TS - 1);
        end
        return e;
    endfunction

    task automatic compare_obs(input string pfx, input obs_t e);
        check_eq({pfx, ".ready"}, 32'(ready), 32'(e.ready));
        check_eq({pfx, ".busy"},  32'(busy),  32'(e.busy));
        check_eq({pfx, ".load"},  32'({reg_a_en, reg_b_en, ac_clr}), 32'(e.ld));
        check_eq({pfx, ".ac_en"}, 32'(ac_en), 32'(e.ac));
        check_eq({pfx, ".lane"},  32'(lane_en), 32'(e.lane));
        check_eq({pfx, ".sign_a"}, 32'(sign_a), 32'(e.sa));
        check_eq({pfx, ".sign_b"}, 32'(sign_b), 32'(e.sb));
        check_eq({pfx, ".sel_a"}, 32'(sel_a), 32'(e.sela));
        check_eq({pfx, ".sel_b"}, 32'(sel_b), 32'(e.selb));
        check_eq({pfx, ".shift"}, 32'(shift), 32'(e.shift));
        check_eq({pfx, ".done"},  32'(done),  32'(e.done));
        check_eq({pfx, ".hi_sel"}, 32'(hi_sel), 32'(e.hi));
    endtask

    task automatic expect_next(input string pfx, input obs_t e);
        obs_t got_e;
        exp_q.push_back(e);
        @(negedge clk);
        got_e = exp_q.pop_front();
        compare_obs(pfx, got_e);
    endtask

    // Called at a falling edge with the DUT idle.
    task automatic run_req(input string nm, input logic [1:0] o, input logic z,
                           input int flush_pass, input int ack_wait);
        valid = 1'b1;
        op    = o;
        zero  = z;
        expect_next({nm, ".load"}, load_exp());
        valid = 1'b0;
        if (!z) begin
            for (int p = 0; p < TP; p++) begin
                expect_next($sformatf("%s.pass%0d", nm, p), mult_exp(o, p));
                lane_log[p] = lane_en;
                sa_log[p]   = sign_a;
                sb_log[p]   = sign_b;
                sela_log[p] = sel_a;
                selb_log[p] = sel_b;
                sh_log[p]   = shift;
                if (p == flush_pass) begin
                    flush = 1'b1;
                    expect_next({nm, ".flushed"}, idle_exp());
                    flush = 1'b0;
                    zero  = 1'b0;
                    return;
                end
            end
        end
        expect_next({nm, ".done"}, done_exp(o));
        zero = 1'b0;
        for (int w = 0; w < ack_wait; w++) begin
            valid = 1'b1;
            expect_next($sformatf("%s.hold%0d", nm, w), done_exp(o));
            valid = 1'b0;
        end
        ack = 1'b1;
        expect_next({nm, ".acked"}, idle_exp());
        ack = 1'b0;
    endtask

    initial begin
        int n_mult;
        rst = 1'b1; valid = 1'b0; op = 2'b00; zero = 1'b0; flush = 1'b0; ack = 1'b0;
        valid2 = 1'b0; ack2 = 1'b0;
        repeat (2) @(negedge clk);
        compare_obs("reset", idle_exp());
        rst = 1'b0;
        expect_next("post_reset", idle_exp());

        run_req("mulhu", 2'b11, 1'b0, -1, 0);
        check_eq("mulhu.sel_a_p0", 32'(sela_log[0]), 32'h0000_00E4);
        check_eq("mulhu.sel_b_p0", 32'(selb_log[0]), 32'h0000_0000);
        check_eq("mulhu.shift_p0", 32'(sh_log[0]), 32'h0000_0688);
        check_eq("mulhu.sel_b_p3", 32'(selb_log[3]), 32'h0000_00FF);
        check_eq("mulhu.shift_p3", 32'(sh_log[3]), 32'h0000_0D63);
        check_eq("mulhu.lane_p3", 32'(lane_log[3]), 32'h0000_000F);

        run_req("mul", 2'b00, 1'b0, -1, 0);
        check_eq("mul.lane_p0", 32'(lane_log[0]), 32'h0000_000F);
        check_eq("mul.lane_p1", 32'(lane_log[1]), 32'h0000_0007);
        check_eq("mul.lane_p2", 32'(lane_log[2]), 32'h0000_0003);
        check_eq("mul.lane_p3", 32'(lane_log[3]), 32'h0000_0001);

        run_req("mulh", 2'b01, 1'b0, -1, 0);
        check_eq("mulh.sign_a_p0", 32'(sa_log[0]), 32'h0000_0008);
        check_eq("mulh.sign_a_p3", 32'(sa_log[3]), 32'h0000_0008);
        check_eq("mulh.sign_b_p2", 32'(sb_log[2]), 32'h0000_0000);
        check_eq("mulh.sign_b_p3", 32'(sb_log[3]), 32'h0000_000F);

        run_req("mulhsu", 2'b10, 1'b0, -1, 0);
        check_eq("mulhsu.sign_a_p1", 32'(sa_log[1]), 32'h0000_0008);
        check_eq("mulhsu.sign_b_p3", 32'(sb_log[3]), 32'h0000_0000);

        run_req("zero", 2'b11, 1'b1, -1, 3);
        run_req("flush", 2'b11, 1'b0, 2, 0);
        run_req("after_flush", 2'b01, 1'b0, -1, 0);

        valid = 1'b1;
        op    = 2'b11;
        expect_next("rst_mid.load", load_exp());
        valid = 1'b0;
        expect_next("rst_mid.pass0", mult_exp(2'b11, 0));
        expect_next("rst_mid.pass1", mult_exp(2'b11, 1));
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid.ready_async", 32'(ready), 32'd1);
        check_eq("rst_mid.busy_async", 32'(busy), 32'd0);
        check_eq("rst_mid.ac_en_async", 32'(ac_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_next("rst_mid.idle", idle_exp());

        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        check_eq("nl2.load", 32'(reg_a_en2), 32'd1);
        n_mult = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ac_en2) n_mult++;
            if (c == 0) begin
                check_eq("nl2.p0_l1_sel_a", 32'(sel_a2[3:2]), 32'd1);
                check_eq("nl2.p0_l1_sel_b", 32'(sel_b2[3:2]), 32'd0);
            end
        end
        check_eq("nl2.mult_cycles", 32'(n_mult), 32'd8);
        @(negedge clk);
        check_eq("nl2.done", 32'(done2), 32'd1);
        check_eq("nl2.hi_sel", 32'(hi_sel2), 32'd1);
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        check_eq("nl2.ready_after_ack", 32'(ready2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
